// File: rtl/relm_uart_pkg.sv
// rtl/relm_uart_pkg.sv - shared encodings and frame constants for the ReLM UART transmitter
package relm_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int   FRAME_BITS = 10;
  localparam int   DATA_BITS  = FRAME_BITS - 2;
  localparam logic STOP_LEVEL = 1'b1;

endpackage

// File: rtl/relm_uart_tx_shifter.sv
// rtl/relm_uart_tx_shifter.sv - 8N1 bit timer, frame FSM and shift register
module relm_uart_tx_shifter
  import relm_uart_pkg::*;
#(
  parameter int CLKDIV = 868,
  localparam int WCD   = $clog2(CLKDIV)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld_req,
  input  logic [7:0] ld_data,
  output logic       ld_ack,
  output logic       txd,
  output logic       active
);

  localparam logic [WCD-1:0] TMAX = WCD'(CLKDIV - 1);

  tx_state_e      state_q, state_d;
  logic [WCD-1:0] timer_q, timer_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     sh_q, sh_d;
  logic           txd_q, txd_d;
  logic           tick;

  assign tick   = (timer_q == TMAX);
  assign txd    = txd_q;
  assign active = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      txd_q   <= STOP_LEVEL;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    ld_ack  = 1'b0;
    txd_d   = STOP_LEVEL;
    // Timer only ever wraps on a bit boundary, so frames stay exactly FRAME_BITS*CLKDIV long.
    if (state_q != ST_IDLE) timer_d = tick ? '0 : timer_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (ld_req) begin
          ld_ack  = 1'b1;
          sh_d    = ld_data;
          timer_d = '0;
          bit_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: if (tick) state_d = ST_DATA;
      ST_DATA: begin
        if (tick) begin
          sh_d  = sh_q >> 1;
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'(DATA_BITS - 1)) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (ld_req) begin
            ld_ack  = 1'b1;
            sh_d    = ld_data;
            bit_d   = '0;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Line level is registered from the next state so txd never glitches.
    case (state_d)
      ST_START: txd_d = ~STOP_LEVEL;
      ST_DATA:  txd_d = sh_d[0];
      default:  txd_d = STOP_LEVEL;
    endcase
  end

endmodule

// File: rtl/relm_uart_tx_io.sv
// rtl/relm_uart_tx_io.sv - buffered UART transmitter on a ReLM PUSH port with POP status
module relm_uart_tx_io
  import relm_uart_pkg::*;
#(
  parameter int WD     = 32,
  parameter int WAD    = 4,
  parameter int CLKDIV = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [WD:0] push_d,
  output logic        push_retry,
  input  logic [WD:0] pop_d,
  output logic [WD:0] pop_q,
  output logic        txd
);

  localparam int DEPTH = 2 ** WAD;

  logic [7:0]   mem_q [DEPTH];
  logic [7:0]   rd_data_q;
  logic         rd_vld_q, rd_vld_d;
  logic [WAD:0] wr_ptr_q, wr_ptr_d;
  logic [WAD:0] rd_ptr_q, rd_ptr_d;
  logic [WAD:0] count_q, count_d;
  logic         full, enq, deq, active, busy;
  logic         unused_bits;

  assign unused_bits = ^{pop_d, push_d[WD-1:8]};

  assign full       = (wr_ptr_q[WAD] != rd_ptr_q[WAD]) &&
                      (wr_ptr_q[WAD-1:0] == rd_ptr_q[WAD-1:0]);
  assign push_retry = push_d[WD] & full & ~deq;
  assign enq        = push_d[WD] & ~push_retry;

  assign wr_ptr_d = wr_ptr_q + {{WAD{1'b0}}, enq};
  assign rd_ptr_d = rd_ptr_q + {{WAD{1'b0}}, deq};

  always_comb begin
    count_d = count_q;
    if (enq && !deq)      count_d = count_q + 1'b1;
    else if (!enq && deq) count_d = count_q - 1'b1;
  end

  // Head data is only trustworthy if that entry was written before this edge.
  assign rd_vld_d = (count_q > {{WAD{1'b0}}, deq});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q[WAD-1:0]] <= push_d[7:0];
    rd_data_q <= mem_q[rd_ptr_d[WAD-1:0]];
  end

  relm_uart_tx_shifter #(.CLKDIV(CLKDIV)) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld_req  (rd_vld_q),
    .ld_data (rd_data_q),
    .ld_ack  (deq),
    .txd     (txd),
    .active  (active)
  );

  assign busy = active | (count_q != '0);

  always_comb begin
    pop_q          = '0;
    pop_q[WAD+1]   = busy;
    pop_q[WAD:0]   = count_q;
  end

endmodule

// File: tb/tb_relm_uart_tx_io.sv
// tb/tb_relm_uart_tx_io.sv - directed self-checking bench for relm_uart_tx_io
module tb_relm_uart_tx_io;

  localparam int WD     = 32;
  localparam int WAD    = 2;
  localparam int CLKDIV = 4;

  logic        clk;
  logic        rst_n;
  logic [WD:0] push_d;
  logic        push_retry;
  logic [WD:0] pop_d;
  logic [WD:0] pop_q;
  logic        txd;

  int n_cmp = 0;
  int n_err = 0;

  relm_uart_tx_io #(.WD(WD), .WAD(WAD), .CLKDIV(CLKDIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_d     (push_d),
    .push_retry (push_retry),
    .pop_d      (pop_d),
    .pop_q      (pop_q),
    .txd        (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Sample order: k=0 is the first start-bit cycle, 4 cycles per bit.
  function automatic logic [39:0] exp_frame(input logic [7:0] b);
    logic [39:0] f;
    int idx;
    for (int k = 0; k < 40; k++) begin
      idx = k / 4;
      if (idx == 0)      f[k] = 1'b0;
      else if (idx == 9) f[k] = 1'b1;
      else               f[k] = b[idx-1];
    end
    return f;
  endfunction

  task automatic capture(input int nbits, output logic [239:0] cap, output int lat);
    cap = '0;
    lat = 0;
    @(negedge clk);
    while (txd !== 1'b0 && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    for (int k = 0; k < nbits; k++) begin
      if (k > 0) @(negedge clk);
      cap[k] = txd;
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    push_d = '0;
    pop_d  = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (txd !== 1'b1) begin n_err++; $display("FAIL reset_txd: got %b want 1", txd); end
    n_cmp++; if (pop_q !== 33'd0) begin n_err++; $display("FAIL reset_pop_q: got %h want 0", pop_q); end
    n_cmp++; if (push_retry !== 1'b0) begin n_err++; $display("FAIL reset_retry: got %b want 0", push_retry); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    logic [239:0] cap;
    int lat;
    push_d = {1'b1, 32'h0000_0055};
    @(negedge clk);
    push_d = '0;
    n_cmp++; if (pop_q !== 33'd9) begin n_err++; $display("FAIL t1_status: got %h want 9", pop_q); end
    n_cmp++; if (txd !== 1'b1) begin n_err++; $display("FAIL t1_txd_t0: got %b want 1", txd); end
    capture(40, cap, lat);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL t1_latency: got %0d want 1", lat); end
    n_cmp++; if (cap[39:0] !== exp_frame(8'h55)) begin n_err++; $display("FAIL t1_frame: got %h want %h", cap[39:0], exp_frame(8'h55)); end
    @(negedge clk);
    n_cmp++; if (pop_q[WAD+1] !== 1'b0) begin n_err++; $display("FAIL t1_busy_after: got %b want 0", pop_q[WAD+1]); end
    n_cmp++; if (txd !== 1'b1) begin n_err++; $display("FAIL t1_idle_txd: got %b want 1", txd); end
  endtask

  task automatic test_back_to_back();
    logic [239:0] cap;
    logic [79:0]  exp;
    int lat;
    exp = {exp_frame(8'h0F), exp_frame(8'hA3)};
    push_d = {1'b1, 32'h0000_00A3};
    @(negedge clk);
    push_d = {1'b1, 32'h0000_000F};
    @(negedge clk);
    push_d = '0;
    capture(80, cap, lat);
    n_cmp++; if (lat !== 0) begin n_err++; $display("FAIL t2_latency: got %0d want 0", lat); end
    n_cmp++; if (cap[79:0] !== exp) begin n_err++; $display("FAIL t2_frames: got %h want %h", cap[79:0], exp); end
    @(negedge clk);
    n_cmp++; if (pop_q !== 33'd0) begin n_err++; $display("FAIL t2_idle: got %h want 0", pop_q); end
  endtask

  task automatic test_overflow();
    logic [239:0] cap;
    logic [239:0] exp;
    logic [7:0]   b [6];
    int lat;
    int rcnt;
    b[0] = 8'h11; b[1] = 8'h82; b[2] = 8'hC4; b[3] = 8'h3D; b[4] = 8'hE7; b[5] = 8'h5A;
    for (int i = 0; i < 6; i++) exp[40*i +: 40] = exp_frame(b[i]);
    rcnt = 0;
    fork
      capture(240, cap, lat);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          push_d = {1'b1, 24'h0, b[i]};
          #1;
          n_cmp++; if (push_retry !== 1'b0) begin n_err++; $display("FAIL t3_accept%0d: retry got %b want 0", i, push_retry); end
        end
        @(negedge clk);
        push_d = {1'b1, 24'h0, b[5]};
        #1;
        n_cmp++; if (push_retry !== 1'b1) begin n_err++; $display("FAIL t3_full_retry: got %b want 1", push_retry); end
        while (push_retry === 1'b1 && rcnt < 100) begin
          rcnt++;
          @(negedge clk);
          #1;
        end
        @(negedge clk);
        push_d = '0;
      end
    join
    n_cmp++; if (rcnt !== 37) begin n_err++; $display("FAIL t3_retry_cycles: got %0d want 37", rcnt); end
    n_cmp++; if (cap !== exp) begin n_err++; $display("FAIL t3_stream: got %h want %h", cap, exp); end
    @(negedge clk);
    n_cmp++; if (pop_q !== 33'd0) begin n_err++; $display("FAIL t3_idle: got %h want 0", pop_q); end
  endtask

  task automatic test_status();
    int wcnt;
    for (int i = 0; i < 4; i++) begin
      push_d = {1'b1, 24'h0, 8'h30 + 8'(i)};
      @(negedge clk);
    end
    push_d = '0;
    pop_d  = {1'b1, 32'hDEAD_BEEF};
    #1;
    n_cmp++; if (pop_q !== 33'h0_0000_000B) begin n_err++; $display("FAIL t4_status: got %h want 00000000b", pop_q); end
    n_cmp++; if (pop_q[WD] !== 1'b0) begin n_err++; $display("FAIL t4_strobe_bit: got %b want 0", pop_q[WD]); end
    @(negedge clk);
    pop_d = '0;
    #1;
    n_cmp++; if (pop_q[WAD:0] !== 3'd3) begin n_err++; $display("FAIL t4_count_kept: got %0d want 3", pop_q[WAD:0]); end
    wcnt = 0;
    while (pop_q[WAD+1] !== 1'b0 && wcnt < 400) begin
      wcnt++;
      @(negedge clk);
    end
    n_cmp++; if (wcnt >= 400) begin n_err++; $display("FAIL t4_drain: busy still %b after %0d cycles", pop_q[WAD+1], wcnt); end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    push_d = {1'b1, 32'h0000_0055};
    @(negedge clk);
    push_d = {1'b1, 32'h0000_0066};
    @(negedge clk);
    push_d = {1'b1, 32'h0000_0077};
    @(negedge clk);
    push_d = '0;
    repeat (17) @(negedge clk);
    #1;
    n_cmp++; if (txd !== 1'b0) begin n_err++; $display("FAIL t5_bit3_level: got %b want 0", txd); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (txd !== 1'b1) begin n_err++; $display("FAIL t5_txd_on_reset: got %b want 1", txd); end
    n_cmp++; if (pop_q !== 33'd0) begin n_err++; $display("FAIL t5_status_on_reset: got %h want 0", pop_q); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (txd !== 1'b1 || pop_q !== 33'd0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL t5_no_restart: %0d non-idle cycles, want 0", bad); end
  endtask

  task automatic test_strobe_and_payload();
    logic [239:0] cap;
    int lat;
    int bad;
    bad = 0;
    push_d = {1'b0, 32'h0000_00FF};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (txd !== 1'b1 || push_retry !== 1'b0 || pop_q !== 33'd0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL t6_no_strobe: %0d active cycles, want 0", bad); end
    push_d = {1'b1, 32'h1234_56C3};
    @(negedge clk);
    push_d = '0;
    n_cmp++; if (pop_q[WAD:0] !== 3'd1) begin n_err++; $display("FAIL t6_count: got %0d want 1", pop_q[WAD:0]); end
    capture(40, cap, lat);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL t6_latency: got %0d want 1", lat); end
    n_cmp++; if (cap[39:0] !== exp_frame(8'hC3)) begin n_err++; $display("FAIL t6_frame: got %h want %h", cap[39:0], exp_frame(8'hC3)); end
    @(negedge clk);
    n_cmp++; if (pop_q !== 33'd0) begin n_err++; $display("FAIL t6_idle: got %h want 0", pop_q); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_status();
    test_reset_mid_frame();
    test_strobe_and_payload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
